// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types, encodings and instruction classifier
package pipe_pkg;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2,
        CLS_NOP = 2'd3
    } instr_class_t;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_ACCESS = S_ACCESS,
        ST_RESP   = S_RESP
    } mem_state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Low opcode nibble of CMP: an ALU op that only sets flags
    localparam logic [3:0] OPC_CMP = 4'b1010;

    localparam logic [1:0] SEL_W_RD = 2'b00;
    localparam logic [1:0] SEL_W_LR = 2'b01;
    localparam logic [1:0] SEL_W_RN = 2'b10;

    localparam logic [1:0] SEL_PC_SEQ = 2'b00;
    localparam logic [1:0] SEL_PC_BR  = 2'b11;

    // MEM and BR are checked first; everything unmatched falls to NOP
    function automatic instr_class_t classify(input logic [6:0] op, input logic [3:0] c);
        if (op[6:5] == 2'b11 || op[6:3] == 4'b1000) return CLS_MEM;
        if (op[6:3] == 4'b1001) return CLS_BR;
        if (!op[6] && op[5:4] != 2'b10 && c != COND_NV) return CLS_ALU;
        return CLS_NOP;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - ARM condition code evaluation against NZCV
module cond_eval
    import pipe_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    // Full condition table; NV is never taken
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage controller with branch epoch squashing
module mem_access_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int EPOCH_W  = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EPOCH_W-1:0] in_epoch,
    input  logic [6:0]         opcode,
    input  logic [3:0]         cond,
    input  logic               P,
    input  logic               U,
    input  logic               W,
    input  logic [3:0]         flags,
    input  logic [ADDR_W-1:0]  base,
    input  logic [ADDR_W-1:0]  offset,
    input  logic [ADDR_W-1:0]  wdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [ADDR_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic               mem_err,
    input  logic [ADDR_W-1:0]  mem_rdata,
    output logic               rd_valid,
    output logic [ADDR_W-1:0]  rd_data,
    output logic               w_en1,
    output logic [1:0]         sel_w_addr1,
    output logic [ADDR_W-1:0]  wb_addr,
    output logic [1:0]         sel_pc,
    output logic               load_pc,
    output logic [EPOCH_W-1:0] epoch,
    output logic               fault,
    input  logic               fault_clr
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    mem_state_t         state_q;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [CNT_W-1:0]   wait_q;
    logic               fault_q;
    logic [ADDR_W-1:0]  addr_q, eff_q, wdata_q, rdata_q;
    logic               we_q, do_wb_q;

    instr_class_t       cls;
    logic               accept, live, br_taken;
    logic               ack_ok, ack_err, timeout, retire_mem;
    logic [ADDR_W-1:0]  eff_in;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags),
        .taken (br_taken)
    );

    // Gating with rst_n keeps every output at 0 while reset is held
    assign in_ready = rst_n & (state_q == ST_IDLE) & ~fault_q;
    assign accept   = in_valid & in_ready;
    assign live     = accept & (in_epoch == epoch_q);
    assign cls      = classify(opcode, cond);
    assign eff_in   = U ? (base + offset) : (base - offset);

    assign ack_ok     = (state_q == ST_ACCESS) & mem_ack & ~mem_err;
    assign ack_err    = (state_q == ST_ACCESS) & mem_ack & mem_err;
    assign timeout    = (state_q == ST_ACCESS) & ~mem_ack & (wait_q == CNT_W'(MAX_WAIT - 1));
    assign retire_mem = (ack_ok & we_q) | (state_q == ST_RESP);

    assign mem_req   = (state_q == ST_ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign fault     = fault_q;
    assign epoch     = epoch_d;

    // Retire pulses: same-cycle for ALU/BR/NOP, ack cycle for stores, RESP for loads
    always_comb begin
        load_pc     = 1'b0;
        w_en1       = 1'b0;
        sel_w_addr1 = SEL_W_RD;
        sel_pc      = SEL_PC_SEQ;
        wb_addr     = '0;
        rd_valid    = 1'b0;
        rd_data     = '0;
        epoch_d     = epoch_q;
        if (live) begin
            case (cls)
                CLS_ALU: begin
                    load_pc = 1'b1;
                    w_en1   = (opcode[3:0] != OPC_CMP);
                end
                CLS_BR: begin
                    load_pc = 1'b1;
                    if (br_taken) begin
                        sel_pc  = SEL_PC_BR;
                        epoch_d = epoch_q + EPOCH_W'(1);
                    end
                    if (opcode[1]) begin
                        w_en1       = 1'b1;
                        sel_w_addr1 = SEL_W_LR;
                    end
                end
                CLS_NOP: load_pc = 1'b1;
                default: ;
            endcase
        end
        if (retire_mem) begin
            load_pc = 1'b1;
            if (do_wb_q) begin
                w_en1       = 1'b1;
                sel_w_addr1 = SEL_W_RN;
                wb_addr     = eff_q;
            end
        end
        if (state_q == ST_RESP) begin
            rd_valid = 1'b1;
            rd_data  = rdata_q;
        end
    end

    // Access FSM, address latching, wait counter, epoch and sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            epoch_q <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            eff_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            do_wb_q <= 1'b0;
        end else begin
            epoch_q <= epoch_d;
            fault_q <= ack_err | timeout | (fault_q & ~fault_clr);
            case (state_q)
                ST_IDLE: begin
                    if (live && cls == CLS_MEM) begin
                        state_q <= ST_ACCESS;
                        wait_q  <= '0;
                        eff_q   <= eff_in;
                        addr_q  <= P ? eff_in : base;
                        we_q    <= opcode[4];
                        wdata_q <= wdata;
                        do_wb_q <= ~P | W;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_err && !we_q) begin
                            state_q <= ST_RESP;
                            rdata_q <= mem_rdata;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                ST_RESP:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int AW = 32;
    localparam int EW = 2;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [EW-1:0] in_epoch = '0;
    logic [6:0]    opcode = '0;
    logic [3:0]    cond = '0;
    logic          P = 1'b0, U = 1'b0, W = 1'b0;
    logic [3:0]    flags = '0;
    logic [AW-1:0] base = '0, offset = '0, wdata = '0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr, mem_wdata;
    logic          mem_ack = 1'b0, mem_err = 1'b0;
    logic [AW-1:0] mem_rdata = '0;
    logic          rd_valid;
    logic [AW-1:0] rd_data;
    logic          w_en1;
    logic [1:0]    sel_w_addr1;
    logic [AW-1:0] wb_addr;
    logic [1:0]    sel_pc;
    logic          load_pc;
    logic [EW-1:0] epoch;
    logic          fault;
    logic          fault_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [EW-1:0] ep_m = '0;

    mem_access_ctrl #(.ADDR_W(AW), .EPOCH_W(EW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_epoch(in_epoch), .opcode(opcode), .cond(cond), .P(P), .U(U), .W(W),
        .flags(flags), .base(base), .offset(offset), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .w_en1(w_en1), .sel_w_addr1(sel_w_addr1),
        .wb_addr(wb_addr), .sel_pc(sel_pc), .load_pc(load_pc), .epoch(epoch),
        .fault(fault), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge and return inputs to their quiet values
    task automatic tick();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        fault_clr = 1'b0;
    endtask

    // 0=ALU 1=MEM 2=BR 3=NOP, from the opcode field rules
    function automatic int m_class(input int op, input int c);
        if ((op >> 5) == 3 || (op >> 3) == 8) return 1;
        if ((op >> 3) == 9) return 2;
        if (op < 64 && ((op >> 4) & 3) != 2 && c != 15) return 0;
        return 3;
    endfunction

    // Even codes test a predicate, odd codes its negation; 15 is never
    function automatic bit m_taken(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !r : r;
    endfunction

    // Present one instruction and check the accept-cycle outputs
    task automatic issue(input logic [6:0] op, input logic [3:0] c, input logic [3:0] f,
                         input logic [EW-1:0] ep, input logic p, input logic u, input logic w,
                         input logic [AW-1:0] b, input logic [AW-1:0] o, input logic [AW-1:0] wd,
                         output bit started);
        int cls;
        bit live, tk, link, wen;
        in_valid = 1'b1; opcode = op; cond = c; flags = f; in_epoch = ep;
        P = p; U = u; W = w; base = b; offset = o; wdata = wd;
        #2;
        cls  = m_class(int'(op), int'(c));
        live = (ep == ep_m);
        tk   = live && cls == 2 && m_taken(c, f);
        link = live && cls == 2 && op[1];
        wen  = (live && cls == 0 && op[3:0] != 4'hA) || link;
        chk("in_ready", in_ready, 1);
        chk("load_pc", load_pc, live && cls != 1);
        chk("w_en1", w_en1, wen);
        chk("sel_w_addr1", sel_w_addr1, link ? 1 : 0);
        chk("sel_pc", sel_pc, tk ? 3 : 0);
        chk("epoch", epoch, (int'(ep_m) + int'(tk)) % 4);
        chk("mem_req_acc", mem_req, 0);
        if (tk) ep_m = ep_m + 1'b1;
        started = live && cls == 1;
    endtask

    // Drive the ACCESS phase; lat = ack cycle index, lat >= MW means never ack
    task automatic mem_run(input bit str, input logic p, input logic u, input logic w,
                           input logic [AW-1:0] b, input logic [AW-1:0] o,
                           input logic [AW-1:0] wd, input int lat, input bit err,
                           input bit clr, input logic [AW-1:0] rdat);
        logic [AW-1:0] eff, addr;
        bit dowb;
        eff  = u ? b + o : b - o;
        addr = p ? eff : b;
        dowb = !p || w;
        for (int k = 0; k < MW; k++) begin
            tick();
            if (k == lat) begin
                mem_ack = 1'b1; mem_err = err; mem_rdata = rdat; fault_clr = clr;
            end
            #2;
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, addr);
            chk("mem_we", mem_we, str);
            if (str) chk("mem_wdata", mem_wdata, wd);
            if (k == lat) begin
                if (!err && str) begin
                    chk("str_load_pc", load_pc, 1);
                    chk("str_w_en1", w_en1, dowb);
                    chk("str_sel_w", sel_w_addr1, dowb ? 2 : 0);
                    chk("str_wb_addr", wb_addr, dowb ? eff : 0);
                end else begin
                    chk("ack_load_pc", load_pc, 0);
                    chk("ack_w_en1", w_en1, 0);
                end
                break;
            end
        end
        if (lat >= MW || err) begin
            tick(); #2;
            chk("flt_mem_req", mem_req, 0);
            chk("flt_fault", fault, 1);
            chk("flt_in_ready", in_ready, 0);
            chk("flt_load_pc", load_pc, 0);
        end else if (!str) begin
            tick(); #2;
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, rdat);
            chk("resp_load_pc", load_pc, 1);
            chk("resp_w_en1", w_en1, dowb);
            chk("resp_sel_w", sel_w_addr1, dowb ? 2 : 0);
            chk("resp_wb_addr", wb_addr, dowb ? eff : 0);
            chk("resp_mem_req", mem_req, 0);
        end
    endtask

    task automatic clear_fault();
        tick();
        fault_clr = 1'b1;
        #2;
        chk("clr_fault_hold", fault, 1);
        chk("clr_ready_hold", in_ready, 0);
        tick(); #2;
        chk("clr_fault", fault, 0);
        chk("clr_in_ready", in_ready, 1);
    endtask

    initial begin
        bit st;
        logic [6:0] op;
        logic [EW-1:0] ep;
        logic [AW-1:0] b, o, wd, rd;
        bit pp, uu, ww, er;
        int kind, lat;

        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_load_pc", load_pc, 0);
        chk("rst_epoch", epoch, 0);
        chk("rst_fault", fault, 0);
        tick();
        rst_n = 1'b1;

        // ALU ADD then CMP
        tick(); issue(7'b0000000, 4'hE, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, st);
        tick(); issue(7'b0001010, 4'hE, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, st);
        chk("cmp_w_en1", w_en1, 0);

        // LS taken, LS not taken, then three AL to wrap the epoch
        tick(); issue(7'b1001000, 4'h9, 4'h6, ep_m, 0, 0, 0, 0, 0, 0, st);
        chk("ls_taken_epoch", epoch, 1);
        tick(); issue(7'b1001000, 4'h9, 4'h2, ep_m, 0, 0, 0, 0, 0, 0, st);
        chk("ls_not_taken", sel_pc, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); issue(7'b1001000, 4'hE, 4'h0, ep_m, 0, 0, 0, 0, 0, 0, st);
        end
        chk("epoch_wrap", epoch, 0);
        tick(); issue(7'b0000000, 4'hE, 4'h0, 2'd3, 0, 0, 0, 0, 0, 0, st);
        chk("squash_load_pc", load_pc, 0);
        tick(); issue(7'b1001010, 4'hF, 4'h0, ep_m, 0, 0, 0, 0, 0, 0, st);
        chk("bl_nt_link", sel_w_addr1, 1);

        // LDR pre-index down with writeback, ack in third ACCESS cycle
        tick(); issue(7'b1100000, 4'hE, 4'h0, ep_m, 1, 0, 1, 32'h100, 32'h8, 0, st);
        mem_run(0, 1, 0, 1, 32'h100, 32'h8, 0, 2, 0, 0, 32'hDEADBEEF);
        chk("ldr_rd_data", rd_data, 32'hDEADBEEF);
        chk("ldr_wb_addr", wb_addr, 32'hF8);

        // STR post-index up wrapping past zero, ack in first cycle
        tick(); issue(7'b1110000, 4'hE, 4'h0, ep_m, 0, 1, 0, 32'hFFFFFFFC, 32'h8, 32'h1234_5678, st);
        mem_run(1, 0, 1, 0, 32'hFFFFFFFC, 32'h8, 32'h1234_5678, 0, 0, 0, 0);

        // Timeout, then clear
        tick(); issue(7'b1100000, 4'hE, 4'h0, ep_m, 1, 1, 0, 32'h40, 32'h4, 0, st);
        mem_run(0, 1, 1, 0, 32'h40, 32'h4, 0, MW, 0, 0, 0);
        clear_fault();

        // Error ack coinciding with fault_clr keeps fault set
        tick(); issue(7'b1000000, 4'hE, 4'h0, ep_m, 1, 1, 1, 32'h80, 32'h4, 0, st);
        mem_run(0, 1, 1, 1, 32'h80, 32'h4, 0, 1, 1, 1, 32'h5);
        clear_fault();

        // Reset during ACCESS with non-zero epoch
        tick(); issue(7'b1001000, 4'hE, 4'h0, ep_m, 0, 0, 0, 0, 0, 0, st);
        tick(); issue(7'b1100000, 4'hE, 4'h0, ep_m, 1, 1, 0, 32'h200, 32'h4, 0, st);
        tick(); #1;
        chk("pre_rst_mem_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_epoch", epoch, 0);
        chk("mid_rst_load_pc", load_pc, 0);
        ep_m = '0;
        tick();
        rst_n = 1'b1;
        tick(); issue(7'b0000001, 4'hE, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, st);
        chk("post_rst_accept", load_pc, 1);

        // Randomized instruction mix against the model
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: op = {1'b0, 6'($urandom)};
                1: op = ($urandom_range(0, 1) == 0) ? {2'b11, 5'($urandom)} : {4'b1000, 3'($urandom)};
                2: op = {4'b1001, 3'($urandom)};
                default: op = 7'($urandom);
            endcase
            ep = ($urandom_range(0, 4) == 0) ? EW'($urandom) : ep_m;
            pp = 1'($urandom); uu = 1'($urandom); ww = 1'($urandom);
            b = $urandom; o = $urandom; wd = $urandom; rd = $urandom;
            tick();
            issue(op, 4'($urandom), 4'($urandom), ep, pp, uu, ww, b, o, wd, st);
            if (st) begin
                lat = $urandom_range(0, 4);
                er  = ($urandom_range(0, 9) == 0);
                mem_run(op[4], pp, uu, ww, b, o, wd, lat, er, 0, rd);
                if (er) clear_fault();
            end
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
